// File: rtl/soc_clk_div.sv
// Free-running integer clock divider: registered clock_slow (low ceil(N/2), high floor(N/2))
// plus a one-cycle tick in the fast domain marking each clock_slow rise.
module soc_clk_div #(
  parameter int clock_rate = 10
) (
  input  logic clock,
  input  logic reset,
  output logic clock_slow,
  output logic tick
);

  localparam int N  = clock_rate;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam int L  = (N + 1) / 2;

  if (N < 2) begin : g_bad_rate
    $error("soc_clk_div: clock_rate must be >= 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] c);
    if (c == CW'(N - 1)) return '0;
    return c + CW'(1);
  endfunction

  always_comb cnt_next = wrap_inc(cnt);

  // Outputs decode cnt_next so they change on the same edge the counter reaches its phase point
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      clock_slow <= 1'b0;
      tick       <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      clock_slow <= (cnt_next >= CW'(L));
      tick       <= (cnt_next == CW'(L));
    end
  end

endmodule

// File: tb/tb_soc_clk_div.sv
// Bench for soc_clk_div: five dividers (N = 2,3,4,5,10) share clock and reset and are
// compared every cycle against a phase-position model, with random async resets.
module tb_soc_clk_div;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic s2, t2, s3, t3, s4, t4, s5, t5, s10, t10;

  soc_clk_div #(.clock_rate(2))  u_n2  (.clock(clock), .reset(reset), .clock_slow(s2),  .tick(t2));
  soc_clk_div #(.clock_rate(3))  u_n3  (.clock(clock), .reset(reset), .clock_slow(s3),  .tick(t3));
  soc_clk_div #(.clock_rate(4))  u_n4  (.clock(clock), .reset(reset), .clock_slow(s4),  .tick(t4));
  soc_clk_div #(.clock_rate(5))  u_n5  (.clock(clock), .reset(reset), .clock_slow(s5),  .tick(t5));
  soc_clk_div #(.clock_rate(10)) u_n10 (.clock(clock), .reset(reset), .clock_slow(s10), .tick(t10));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;  // rising edges seen with reset high since the last release

  int seq4[10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  int tk4[10]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  int seq5[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
  int tk5[10]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  int seq2[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
  endtask

  // Position within the slow period: first L edges low, next H edges high.
  function automatic int exp_slow(input int n, input int kk);
    return ((kk % n) >= (n + 1) / 2) ? 1 : 0;
  endfunction

  function automatic int exp_tick(input int n, input int kk);
    return ((kk % n) == (n + 1) / 2) ? 1 : 0;
  endfunction

  task automatic check_all();
    chk("n2_slow",  s2,  exp_slow(2, k));   chk("n2_tick",  t2,  exp_tick(2, k));
    chk("n3_slow",  s3,  exp_slow(3, k));   chk("n3_tick",  t3,  exp_tick(3, k));
    chk("n4_slow",  s4,  exp_slow(4, k));   chk("n4_tick",  t4,  exp_tick(4, k));
    chk("n5_slow",  s5,  exp_slow(5, k));   chk("n5_tick",  t5,  exp_tick(5, k));
    chk("n10_slow", s10, exp_slow(10, k));  chk("n10_tick", t10, exp_tick(10, k));
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) k++;
    @(negedge clock);
    check_all();
  endtask

  // Called at a falling edge: pulls reset mid-cycle, checks the async clear, holds, releases.
  task automatic do_reset();
    #($urandom_range(1, 3));
    reset = 1'b0;
    k = 0;
    #1;
    chk("rst_async_s2", s2, 0);   chk("rst_async_t2", t2, 0);
    chk("rst_async_s3", s3, 0);   chk("rst_async_t3", t3, 0);
    chk("rst_async_s4", s4, 0);   chk("rst_async_t4", t4, 0);
    chk("rst_async_s5", s5, 0);   chk("rst_async_t5", t5, 0);
    chk("rst_async_s10", s10, 0); chk("rst_async_t10", t10, 0);
    repeat ($urandom_range(1, 3)) step();
    #($urandom_range(1, 3));
    reset = 1'b1;
  endtask

  task automatic run_tables();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("tbl_n4_slow", s4, seq4[i]);
      chk("tbl_n4_tick", t4, tk4[i]);
      chk("tbl_n5_slow", s5, seq5[i]);
      chk("tbl_n5_tick", t5, tk5[i]);
      chk("tbl_n2_slow", s2, seq2[i]);
      chk("tbl_n2_tick", t2, seq2[i]);
    end
  endtask

  initial begin
    int rises, ticks, run, prev, seen;
    int hi_min, hi_max, lo_min, lo_max;

    repeat (3) step();
    #2 reset = 1'b1;
    run_tables();

    // Reset while the N=4 divider is high, then the sequence must restart from edge 1
    for (int i = 0; i < 8 && s4 == 1'b0; i++) step();
    chk("n4_high_before_rst", s4, 1);
    do_reset();
    run_tables();

    repeat (12) begin
      repeat ($urandom_range(1, 40)) step();
      do_reset();
    end

    rises = 0; ticks = 0; run = 0; prev = 0; seen = 0;
    hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
    step();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step();
      if (t10) ticks++;
      if (s10 && prev == 0) rises++;
      if (int'(s10) != prev) begin
        if (seen != 0) begin
          if (prev != 0) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end else begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
        end
        seen = 1;
        run = 1;
      end else begin
        run++;
      end
      prev = s10;
    end
    chk("n10_rises", rises, 100);
    chk("n10_ticks", ticks, 100);
    chk("n10_hi_min", hi_min, 5);
    chk("n10_hi_max", hi_max, 5);
    chk("n10_lo_min", lo_min, 5);
    chk("n10_lo_max", lo_max, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_clk_div.md
SOC_CLK_DIV -- requirements
Module: soc_clk_div

Interface
REQ-001 Parameter clock_rate, default 10, integer division ratio N; clock_slow period equals N input clock periods.
REQ-002 Port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 Port clock_slow  output  1  divided clock; a registered signal, never combinationally derived from clock.
REQ-005 Port tick  output  1  single-cycle pulse in the clock domain; high for exactly the one clock cycle in which clock_slow first reads 1 in each slow period.

Function
REQ-006 Internal counter cnt, width ceil(log2(N)) with a minimum of 1 bit, ranges 0..N-1.
REQ-007 Define L = ceil(N/2) as the low-phase length and H = floor(N/2) as the high-phase length, both in clock cycles.
REQ-008 Every rising clock edge out of reset: cnt_next = 0 if cnt == N-1, else cnt+1; cnt <= cnt_next.
REQ-009 Every rising clock edge out of reset: clock_slow <= 1 if cnt_next >= L, else 0.
REQ-010 Every rising clock edge out of reset: tick <= 1 if cnt_next == L, else 0.
REQ-011 After reset release, clock_slow stays 0 for L cycles, then is 1 for H cycles, then repeats (0 for L, 1 for H) indefinitely.
REQ-012 Duty cycle: exactly 50 % for even N; for odd N the low phase is one cycle longer than the high phase.
REQ-013 Wrap-around: cnt N-1 -> 0 coincides with the clock_slow 1 -> 0 transition; no glitch or extra cycle at the wrap.
REQ-014 clock_rate < 2 is illegal; elaboration SHALL fail with an error message.
REQ-015 N = 2: clock_slow toggles every clock cycle (0,1,0,1,...), first 1 at the 1st edge after reset release; tick high every other cycle.
REQ-016 No other inputs; the divider runs free whenever reset is high.

Reset
REQ-017 Assertion of reset (low) SHALL immediately and asynchronously force cnt = 0, clock_slow = 0 and tick = 0, regardless of clock.
REQ-018 Outputs SHALL hold 0 for as long as reset is low.
REQ-019 Reset asserted mid-period SHALL abandon the current period; after release the sequence restarts exactly as in REQ-011, with no partial phase.
REQ-020 The first counting edge is the first rising clock edge with reset high.

Verification
REQ-021 N = 4, reset released -> clock_slow sequence over edges 1..8: 0,1,1,0,0,1,1,0; tick high only at edges 2 and 6.
REQ-022 N = 5 -> clock_slow per edge 1..10: 0,0,1,1,0,0,0,1,1,0 (low 3 cycles, high 2); tick high at edges 3 and 8.
REQ-023 N = 2 -> clock_slow toggles every edge, starting 1 at edge 1; period = 2 clock cycles.
REQ-024 N = 4, reset pulled low asynchronously between edges while clock_slow = 1 -> clock_slow = 0 without waiting for a clock edge; after release the sequence matches REQ-021 from edge 1.
REQ-025 N = 10 free-running for 1000 cycles -> exactly 100 rising edges of clock_slow, each high phase 5 cycles, each low phase 5 cycles, 100 tick pulses.
REQ-026 clock_rate = 1 -> elaboration error reported and simulation does not start.
